// File: rtl/va_pio_pkg.sv
`default_nettype none
// ============================================================================
// Module  : va_pio_pkg
// Purpose : Register map, edge-mode encoding and address split helpers for
//           the va_pio_bank Avalon-MM PIO bank.
// Rev     : 1.0  initial release
// ============================================================================
package va_pio_pkg;

    localparam logic [2:0] REG_DATA_IN   = 3'd0;
    localparam logic [2:0] REG_DATA_OUT  = 3'd1;
    localparam logic [2:0] REG_OUT_SET   = 3'd2;
    localparam logic [2:0] REG_OUT_CLR   = 3'd3;
    localparam logic [2:0] REG_IRQ_MASK  = 3'd4;
    localparam logic [2:0] REG_EDGE_CAP  = 3'd5;
    localparam logic [2:0] REG_EDGE_MODE = 3'd6;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_BOTH = 2'd2,
        EDGE_OFF  = 2'd3
    } edge_mode_t;

    // Word address is {channel, reg}; callers zero-extend to 32 bits first.
    function automatic logic [2:0] addr_reg(input logic [31:0] a);
        return 3'(a);
    endfunction

    function automatic logic [31:0] addr_chan(input logic [31:0] a);
        return a >> 3;
    endfunction

endpackage
`default_nettype wire

// File: rtl/va_pio_bank_if.sv
`default_nettype none
// ============================================================================
// Module  : va_pio_bank_if
// Purpose : Avalon-MM slave bus bundle for va_pio_bank.
// Rev     : 1.0  initial release
// ============================================================================
interface va_pio_bank_if #(
    parameter int AW = 5
) ();
    logic [AW-1:0] avs_address;
    logic          avs_read;
    logic          avs_write;
    logic [31:0]   avs_writedata;
    logic [31:0]   avs_readdata;

    modport slave (
        input  avs_address,
        input  avs_read,
        input  avs_write,
        input  avs_writedata,
        output avs_readdata
    );

    modport master (
        output avs_address,
        output avs_read,
        output avs_write,
        output avs_writedata,
        input  avs_readdata
    );
endinterface
`default_nettype wire

// File: rtl/va_pio_chan.sv
`default_nettype none
// ============================================================================
// Module  : va_pio_chan
// Purpose : One PIO channel: synchroniser, debounce, edge capture and the
//           DATA_OUT / IRQ_MASK / EDGE_CAP / EDGE_MODE registers.
// Rev     : 1.0  initial release
// ============================================================================
module va_pio_chan
    import va_pio_pkg::*;
#(
    parameter int           W         = 32,
    parameter int           DEBOUNCE  = 0,
    parameter logic [W-1:0] OUT_RESET = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_pin,
    input  logic         i_wr,
    input  logic [2:0]   i_reg,
    input  logic [31:0]  i_wdata,
    output logic [W-1:0] o_data_in,
    output logic [W-1:0] o_data_out,
    output logic [W-1:0] o_mask,
    output logic [W-1:0] o_cap,
    output edge_mode_t   o_mode,
    output logic         o_irq
);

    logic [W-1:0] r_sync1;
    logic [W-1:0] r_sync2;
    logic [W-1:0] r_filt;
    logic [W-1:0] r_filt_d;
    logic [W-1:0] r_out;
    logic [W-1:0] r_mask;
    logic [W-1:0] r_cap;
    edge_mode_t   r_mode;
    logic [W-1:0] w_wd;
    logic [W-1:0] w_set;
    logic [W-1:0] w_clr;

    assign w_wd = i_wdata[W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_pin;
            r_sync2 <= r_sync1;
        end
    end

    generate
        if (DEBOUNCE == 0) begin : g_bypass
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_filt <= '0;
                else        r_filt <= r_sync2;
            end
        end else begin : g_filter
            localparam int CW = $clog2(DEBOUNCE + 1);
            logic [CW-1:0] r_cnt;
            logic [W-1:0]  r_last;

            // r_last detects a synced-word change mid-count so the count restarts.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt  <= '0;
                    r_last <= '0;
                    r_filt <= '0;
                end else begin
                    r_last <= r_sync2;
                    if (r_sync2 == r_filt) begin
                        r_cnt <= '0;
                    end else if (r_sync2 != r_last) begin
                        r_cnt <= CW'(1);
                    end else if (r_cnt == CW'(DEBOUNCE)) begin
                        r_filt <= r_sync2;
                        r_cnt  <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        w_set = '0;
        case (r_mode)
            EDGE_RISE: w_set = r_filt & ~r_filt_d;
            EDGE_FALL: w_set = ~r_filt & r_filt_d;
            EDGE_BOTH: w_set = r_filt ^ r_filt_d;
            default:   w_set = '0;
        endcase
    end

    assign w_clr = (i_wr && (i_reg == REG_EDGE_CAP)) ? w_wd : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_filt_d <= '0;
            r_out    <= OUT_RESET;
            r_mask   <= '0;
            r_cap    <= '0;
            r_mode   <= EDGE_RISE;
        end else begin
            r_filt_d <= r_filt;
            // Applying the set after the clear lets a fresh edge beat a W1C.
            r_cap    <= (r_cap & ~w_clr) | w_set;
            if (i_wr) begin
                case (i_reg)
                    REG_DATA_OUT:  r_out  <= w_wd;
                    REG_OUT_SET:   r_out  <= r_out | w_wd;
                    REG_OUT_CLR:   r_out  <= r_out & ~w_wd;
                    REG_IRQ_MASK:  r_mask <= w_wd;
                    REG_EDGE_MODE: r_mode <= edge_mode_t'(i_wdata[1:0]);
                    default: ;
                endcase
            end
        end
    end

    assign o_data_in  = r_filt;
    assign o_data_out = r_out;
    assign o_mask     = r_mask;
    assign o_cap      = r_cap;
    assign o_mode     = r_mode;
    assign o_irq      = |(r_cap & r_mask);

endmodule
`default_nettype wire

// File: rtl/va_pio_bank.sv
`default_nettype none
// ============================================================================
// Module  : va_pio_bank
// Purpose : CH-channel Avalon-MM PIO bank with debounced inputs, edge capture,
//           maskable level IRQ and atomic set/clear outputs.
// Rev     : 1.0  initial release
// ============================================================================
module va_pio_bank
    import va_pio_pkg::*;
#(
    parameter int           CH        = 4,
    parameter int           W         = 32,
    parameter int           DEBOUNCE  = 0,
    parameter logic [W-1:0] OUT_RESET = '0
) (
    input  logic            clk_clk,
    input  logic            reset_reset_n,
    va_pio_bank_if.slave    avs,
    output logic            irq,
    input  logic [CH*W-1:0] pio_in,
    output logic [CH*W-1:0] pio_out
);

    logic [31:0]  w_addr;
    logic [31:0]  w_chan;
    logic [2:0]   w_reg;
    logic [31:0]  w_rdata;
    logic [31:0]  r_rdata;
    logic         r_irq;
    logic [CH-1:0] w_irq;
    logic [W-1:0] w_din  [CH];
    logic [W-1:0] w_dout [CH];
    logic [W-1:0] w_mask [CH];
    logic [W-1:0] w_cap  [CH];
    edge_mode_t   w_mode [CH];

    assign w_addr = 32'(avs.avs_address);
    assign w_chan = addr_chan(w_addr);
    assign w_reg  = addr_reg(w_addr);

    generate
        for (genvar c = 0; c < CH; c++) begin : g_chan
            va_pio_chan #(
                .W         (W),
                .DEBOUNCE  (DEBOUNCE),
                .OUT_RESET (OUT_RESET)
            ) u_chan (
                .clk        (clk_clk),
                .rst_n      (reset_reset_n),
                .i_pin      (pio_in[c*W +: W]),
                .i_wr       (avs.avs_write && (w_chan == 32'(c))),
                .i_reg      (w_reg),
                .i_wdata    (avs.avs_writedata),
                .o_data_in  (w_din[c]),
                .o_data_out (w_dout[c]),
                .o_mask     (w_mask[c]),
                .o_cap      (w_cap[c]),
                .o_mode     (w_mode[c]),
                .o_irq      (w_irq[c])
            );
            assign pio_out[c*W +: W] = w_dout[c];
        end
    endgenerate

    // Out-of-range channels, write-only and reserved offsets all fall to 0.
    always_comb begin
        w_rdata = '0;
        for (int c = 0; c < CH; c++) begin
            if (w_chan == 32'(c)) begin
                case (w_reg)
                    REG_DATA_IN:   w_rdata = 32'(w_din[c]);
                    REG_DATA_OUT:  w_rdata = 32'(w_dout[c]);
                    REG_IRQ_MASK:  w_rdata = 32'(w_mask[c]);
                    REG_EDGE_CAP:  w_rdata = 32'(w_cap[c]);
                    REG_EDGE_MODE: w_rdata = 32'(w_mode[c]);
                    default:       w_rdata = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_rdata <= '0;
            r_irq   <= 1'b0;
        end else begin
            if (avs.avs_read) r_rdata <= w_rdata;
            r_irq <= |w_irq;
        end
    end

    assign avs.avs_readdata = r_rdata;
    assign irq              = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_va_pio_bank.sv
`default_nettype none
// ============================================================================
// Module  : tb_va_pio_bank
// Purpose : Directed self-checking bench for va_pio_bank (CH=5, W=8,
//           DEBOUNCE=8, OUT_RESET=8'hA5).
// Rev     : 1.0  initial release
// ============================================================================
module tb_va_pio_bank;

    localparam int CH = 5;
    localparam int W  = 8;
    localparam int DB = 8;
    localparam int AW = $clog2(CH) + 3;
    localparam logic [W-1:0] RST_OUT = 8'hA5;

    logic            clk;
    logic            rst_n;
    logic            irq;
    logic [CH*W-1:0] pio_in;
    logic [CH*W-1:0] pio_out;
    logic [CH*W-1:0] exp_out;
    logic [31:0]     rd;
    int              n_checks;
    int              n_fail;

    va_pio_bank_if #(.AW(AW)) avs_if ();

    va_pio_bank #(
        .CH        (CH),
        .W         (W),
        .DEBOUNCE  (DB),
        .OUT_RESET (RST_OUT)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .avs           (avs_if),
        .irq           (irq),
        .pio_in        (pio_in),
        .pio_out       (pio_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_addr(input int ch, input int r);
        avs_if.avs_address = AW'((ch << 3) | r);
    endtask

    task automatic bus_write(input int ch, input int r, input logic [31:0] d);
        @(negedge clk);
        set_addr(ch, r);
        avs_if.avs_writedata = d;
        avs_if.avs_write     = 1'b1;
        @(negedge clk);
        avs_if.avs_write     = 1'b0;
    endtask

    task automatic bus_read(input int ch, input int r, output logic [31:0] d);
        @(negedge clk);
        set_addr(ch, r);
        avs_if.avs_read = 1'b1;
        @(negedge clk);
        avs_if.avs_read = 1'b0;
        d = avs_if.avs_readdata;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        pio_in   = '0;
        avs_if.avs_address   = '0;
        avs_if.avs_read      = 1'b0;
        avs_if.avs_write     = 1'b0;
        avs_if.avs_writedata = '0;
        repeat (3) @(negedge clk);

        // Reset state
        exp_out = {CH{RST_OUT}};
        check("rst_pio_out", 64'(pio_out), 64'(exp_out));
        check("rst_irq", 64'(irq), 64'd0);
        check("rst_readdata", 64'(avs_if.avs_readdata), 64'd0);
        rst_n = 1'b1;
        for (int r = 0; r < 8; r++) begin
            bus_read(0, r, rd);
            check($sformatf("rst_reg%0d", r), 64'(rd), (r == 1) ? 64'hA5 : 64'd0);
        end

        // Atomic set/clear on channel 2
        bus_write(2, 1, 32'h0F);
        bus_write(2, 2, 32'hF0);
        bus_write(2, 3, 32'h03);
        check("ch2_pio_out", 64'(pio_out[2*W +: W]), 64'hFC);
        bus_read(2, 1, rd);
        check("ch2_data_out", 64'(rd), 64'hFC);
        bus_write(3, 1, 32'h1FF);
        bus_read(3, 1, rd);
        check("ch3_upper_bits", 64'(rd), 64'hFF);

        // Out-of-range channel and write-only register
        bus_write(5, 1, 32'h12);
        bus_write(5, 4, 32'hFF);
        bus_read(5, 1, rd);
        check("ch5_read", 64'(rd), 64'd0);
        bus_read(2, 2, rd);
        check("out_set_read", 64'(rd), 64'd0);
        exp_out = {RST_OUT, 8'hFF, 8'hFC, RST_OUT, RST_OUT};
        check("oob_no_effect", 64'(pio_out), 64'(exp_out));
        bus_read(4, 4, rd);
        check("ch4_mask_untouched", 64'(rd), 64'd0);

        // Debounce: short pulse rejected, long pulse accepted after 2+8+1 cycles
        @(negedge clk);
        set_addr(0, 0);
        avs_if.avs_read = 1'b1;
        pio_in[0] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check($sformatf("db_short_%0d", k), 64'(avs_if.avs_readdata), 64'd0);
        end
        pio_in[0] = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            check($sformatf("db_gap_%0d", k), 64'(avs_if.avs_readdata), 64'd0);
        end
        pio_in[0] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            // readdata lags DATA_IN by one cycle: DATA_IN flips at edge 11
            check($sformatf("db_long_%0d", k), 64'(avs_if.avs_readdata), (k == 12) ? 64'd1 : 64'd0);
        end
        pio_in[0] = 1'b0;
        avs_if.avs_read = 1'b0;
        repeat (15) @(negedge clk);
        bus_read(0, 5, rd);
        check("ch0_cap_rise", 64'(rd), 64'd1);
        bus_write(0, 5, 32'h1);
        bus_read(0, 5, rd);
        check("ch0_cap_w1c", 64'(rd), 64'd0);

        // Both-edge capture on ch1 bit3 with interrupt
        bus_write(1, 6, 32'h2);
        bus_write(1, 4, 32'h8);
        bus_read(1, 6, rd);
        check("ch1_mode", 64'(rd), 64'd2);
        @(negedge clk);
        pio_in[W + 3] = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            check($sformatf("irq_rise_%0d", k), 64'(irq), (k >= 13) ? 64'd1 : 64'd0);
        end
        bus_read(1, 5, rd);
        check("ch1_cap_rise", 64'(rd), 64'h8);
        bus_write(1, 5, 32'h8);
        @(negedge clk);
        check("irq_cleared", 64'(irq), 64'd0);

        // Falling edge arriving on the same edge as a W1C of that bit
        @(negedge clk);
        pio_in[W + 3] = 1'b0;
        repeat (11) @(negedge clk);
        set_addr(1, 5);
        avs_if.avs_writedata = 32'h8;
        avs_if.avs_write     = 1'b1;
        @(negedge clk);
        avs_if.avs_write     = 1'b0;
        check("irq_fall_pre", 64'(irq), 64'd0);
        @(negedge clk);
        check("irq_fall", 64'(irq), 64'd1);
        bus_read(1, 5, rd);
        check("cap_set_wins", 64'(rd), 64'h8);

        // Reset mid-debounce with interrupt pending
        @(negedge clk);
        pio_in[W + 3] = 1'b1;
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_irq", 64'(irq), 64'd0);
        check("rst_async_rd", 64'(avs_if.avs_readdata), 64'd0);
        exp_out = {CH{RST_OUT}};
        check("rst_async_out", 64'(pio_out), 64'(exp_out));
        pio_in = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bus_read(1, 0, rd);
        check("post_rst_data_in", 64'(rd), 64'd0);
        bus_read(1, 5, rd);
        check("post_rst_cap", 64'(rd), 64'd0);
        bus_read(1, 4, rd);
        check("post_rst_mask", 64'(rd), 64'd0);
        bus_read(2, 1, rd);
        check("post_rst_out", 64'(rd), 64'hA5);
        check("post_rst_irq", 64'(irq), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
